cac_decoder_seq: RTL and testbench
==================================

CAC_DECODER_SEQ -- requirements
Module: cac_decoder_seq

Interface
REQ-001 Parameter CW, default 4: codeword width in bits; legal range 2..16.
REQ-002 Parameter DW, default 3: decoded data width in bits; legal range 1..CW.
REQ-003 clock  input  1  single clock for the whole block; all state updates on posedge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 code_in  input  CW  Fibonacci-numeral-system (FNS) CAC codeword; bit 0 is the least-significant weight.
REQ-006 in_valid  input  1  code_in is valid this cycle.
REQ-007 in_ready  output  1  block can accept a codeword this cycle.
REQ-008 data_out  output  DW  decoded data word.
REQ-009 ovf_out  output  1  decoded value exceeds 2^DW-1.
REQ-010 adj_out  output  1  codeword contains at least one pair of adjacent 1 bits (non-canonical FNS form).
REQ-011 out_valid  output  1  data_out, ovf_out and adj_out are valid.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-013 The block SHALL compute the FNS weights internally: w0=1, w1=2, wk=w(k-1)+w(k-2); for CW=4 the weights are 1,2,3,5.
REQ-014 The decoded value SHALL be the sum of wk over all k where code_in[k]=1, held in a CW-bit accumulator; overflow of this accumulator is impossible by construction.
REQ-015 The FSM SHALL have three states: IDLE, DECODE and DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid=1 the block SHALL capture code_in, clear the accumulator, load the weight pair (1,2), clear the bit index and adj flag, and go to DECODE.
REQ-017 DECODE: in_ready=0; each cycle the block SHALL process one bit (index 0 upward): add the current weight if the bit is 1, set adj if the bit and the next-higher bit are both 1, advance the weight pair (w,wn)->(wn,w+wn), and increment the index.
REQ-018 After exactly CW DECODE cycles the FSM SHALL go to DONE; out_valid SHALL first be 1 in cycle CW+1 after the accepting edge (latency CW+1 cycles).
REQ-019 DONE: out_valid=1, in_ready=0; data_out=acc[DW-1:0], ovf_out=(acc>2^DW-1), adj_out=adj flag; all outputs SHALL remain stable until out_ready=1.
REQ-020 On out_valid=1 and out_ready=1 the FSM SHALL return to IDLE; in_ready is 1 on the following cycle. Results are not pipelined, so throughput is one word per CW+2 cycles.
REQ-021 in_valid asserted while in_ready=0 SHALL be ignored; code_in changes during DECODE SHALL NOT affect the result.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 data_out, ovf_out and adj_out SHALL be registered outputs, updated only on entry to DONE.

Reset
REQ-024 Asserting reset SHALL immediately force IDLE: in_ready=1, out_valid=0, data_out=0, ovf_out=0, adj_out=0, and clear the accumulator, weights, index and captured codeword.
REQ-025 Reset asserted during DECODE or DONE SHALL abort the word in progress; no result for that word SHALL ever appear.
REQ-026 After reset is released, the first posedge with in_valid=1 SHALL be accepted.

Verification
REQ-027 CW=4, DW=3: code_in=4'b1010 accepted -> 5 cycles later out_valid=1, data_out=7, ovf_out=0, adj_out=0.
REQ-028 code_in=4'b0000 -> data_out=0, ovf_out=0, adj_out=0; code_in=4'b0101 -> data_out=4, ovf_out=0, adj_out=0.
REQ-029 code_in=4'b1111 -> sum 11: data_out=3, ovf_out=1, adj_out=1.
REQ-030 Back-pressure: hold out_ready=0 for 6 cycles in DONE -> outputs stay constant and in_ready stays 0; in_valid pulses in that window are ignored; with out_ready=1, IDLE is reached on the next edge.
REQ-031 Assert reset in the 2nd DECODE cycle of code_in=4'b1000 -> all outputs go to 0 and in_ready to 1 at once; a following code_in=4'b0011 produces data_out=3, adj_out=1, with no trace of the aborted word.
REQ-032 Sweep all 16 codewords back-to-back with random out_ready -> each result matches a reference weighted sum and its ovf/adj flags, in order, with no loss and no duplication.

Source files
------------

// File: rtl/cac_decoder_seq.sv
// Sequential decoder for Fibonacci-numeral-system CAC codewords: one bit per cycle,
// producing the weighted sum, an overflow flag and a non-canonical (adjacent ones) flag.
module cac_decoder_seq #(
    parameter int unsigned CW = 4,
    parameter int unsigned DW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [CW-1:0] code_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] data_out,
    output logic          ovf_out,
    output logic          adj_out,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int unsigned IW = $clog2(CW + 1);
    localparam logic [IW-1:0] LastIdx = IW'(CW - 1);
    // Largest value representable in DW bits, widened so the compare never truncates.
    localparam logic [CW:0] DataMax = {(CW + 1){1'b1}} >> (CW + 1 - DW);

    typedef enum logic [1:0] {StIdle, StDecode, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] code_q, acc_q, w_q, wn_q;
    logic [IW-1:0] idx_q;
    logic          adj_q;
    logic [DW-1:0] data_q;
    logic          ovf_q, res_adj_q;

    logic [CW-1:0] acc_nxt;
    logic          adj_nxt;
    logic          last_bit;
    logic          accept;

    assign accept   = (state_q == StIdle) && in_valid;
    assign last_bit = (idx_q == LastIdx);
    // The captured word shifts right, so bit 0 is always the bit under decode.
    assign acc_nxt  = acc_q + (code_q[0] ? w_q : '0);
    assign adj_nxt  = adj_q | (code_q[0] & code_q[1]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (in_valid)  state_d = StDecode;
            StDecode: if (last_bit)  state_d = StDone;
            StDone:   if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle:   in_ready  = 1'b1;
            StDecode: ;
            StDone:   out_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            code_q    <= '0;
            acc_q     <= '0;
            w_q       <= '0;
            wn_q      <= '0;
            idx_q     <= '0;
            adj_q     <= 1'b0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            res_adj_q <= 1'b0;
        end else if (accept) begin
            code_q <= code_in;
            acc_q  <= '0;
            w_q    <= CW'(1);
            wn_q   <= CW'(2);
            idx_q  <= '0;
            adj_q  <= 1'b0;
        end else if (state_q == StDecode) begin
            code_q <= {1'b0, code_q[CW-1:1]};
            acc_q  <= acc_nxt;
            w_q    <= wn_q;
            wn_q   <= w_q + wn_q;
            idx_q  <= idx_q + IW'(1);
            adj_q  <= adj_nxt;
            if (last_bit) begin
                data_q    <= acc_nxt[DW-1:0];
                ovf_q     <= {1'b0, acc_nxt} > DataMax;
                res_adj_q <= adj_nxt;
            end
        end
    end

    assign data_out = data_q;
    assign ovf_out  = ovf_q;
    assign adj_out  = res_adj_q;

endmodule

// File: tb/tb_cac_decoder_seq.sv
// Directed bench for cac_decoder_seq (CW=4, DW=3): latency, flags, back-pressure,
// mid-word reset and a back-to-back sweep of all codewords.
module tb_cac_decoder_seq;

    logic       clock;
    logic       reset;
    logic [3:0] code_in;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] data_out;
    logic       ovf_out;
    logic       adj_out;
    logic       out_valid;
    logic       out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    // Hand-computed weighted sums for codes 0..15 with weights 1,2,3,5.
    int          sum_tbl [16] = '{0, 1, 2, 3, 3, 4, 5, 6, 5, 6, 7, 8, 8, 9, 10, 11};
    // Bit i set when code i has adjacent ones: 3,6,7,11,12,13,14,15.
    logic [15:0] adj_tbl = 16'hF8C8;

    cac_decoder_seq #(.CW(4), .DW(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .ovf_out   (ovf_out),
        .adj_out   (adj_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_result(input string tag, input int sum, input logic adj);
        check({tag, "_data"}, 32'(data_out), 32'(sum % 8));
        check({tag, "_ovf"}, 32'(ovf_out), 32'(sum > 7));
        check({tag, "_adj"}, 32'(adj_out), 32'(adj));
    endtask

    // Called at posedge+1 with the block idle; returns with the result in DONE.
    task automatic do_word(input logic [3:0] code, input int sum, input logic adj);
        int cyc;
        check("pre_ready", 32'(in_ready), 1);
        code_in  = code;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        code_in  = ~code;
        check("busy_ready", 32'(in_ready), 0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 4);
        check_result("word", sum, adj);
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("rel_ready", 32'(in_ready), 1);
        check("rel_valid", 32'(out_valid), 0);
    endtask

    initial begin
        int  cyc;
        int  tries;
        bit  done;
        reset     = 1'b1;
        code_in   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_ready", 32'(in_ready), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(data_out), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        do_word(4'b1010, 7, 1'b0);
        release_word();
        do_word(4'b0000, 0, 1'b0);
        release_word();
        do_word(4'b0101, 4, 1'b0);
        release_word();

        // Back-pressure with in_valid pulses that must be ignored.
        do_word(4'b1010, 7, 1'b0);
        for (int k = 0; k < 6; k++) begin
            in_valid = k[0];
            code_in  = 4'b1111;
            @(posedge clock); #1;
            check("bp_valid", 32'(out_valid), 1);
            check("bp_ready", 32'(in_ready), 0);
            check_result("bp", 7, 1'b0);
        end
        in_valid = 1'b0;
        release_word();
        @(posedge clock); #1;
        check("bp_idle", 32'(in_ready), 1);

        do_word(4'b1111, 11, 1'b1);
        release_word();

        // Reset in the 2nd DECODE cycle of 1000 clears the prior result too.
        code_in  = 4'b1000;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("ar_ready", 32'(in_ready), 1);
        check("ar_valid", 32'(out_valid), 0);
        check_result("ar", 0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            check("ar_quiet", 32'(out_valid), 0);
        end
        do_word(4'b0011, 3, 1'b1);
        release_word();

        // Back-to-back sweep: in_valid held high, random out_ready throughout.
        in_valid = 1'b1;
        code_in  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            check("sw_ready", 32'(in_ready), 1);
            @(posedge clock); #1;
            code_in = 4'((i + 1) % 16);
            if (i == 15) in_valid = 1'b0;
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clock); #1;
                cyc++;
            end
            check("sw_latency", 32'(cyc), 4);
            check_result("sw", sum_tbl[i], adj_tbl[i]);
            tries = 0;
            done  = 1'b0;
            while (!done) begin
                out_ready = (tries >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clock); #1;
                if (out_ready) begin
                    done = 1'b1;
                end else begin
                    check("sw_hold_ready", 32'(in_ready), 0);
                    check_result("sw_hold", sum_tbl[i], adj_tbl[i]);
                end
                tries++;
            end
            out_ready = 1'b0;
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            check("sw_end_valid", 32'(out_valid), 0);
        end
        check("sw_end_ready", 32'(in_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
